// File: rtl/score_pkg.sv
// Shared types and constants for the whack-a-mole score bookkeeping.
package score_pkg;

  localparam logic [6:0] ASCII_ZERO = 7'h30;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_updown2.sv
// Two-digit BCD up/down counter, saturating at 99 and flooring at 00.
// The next-state digits are exported so the caller can act on the post-update value.
module bcd_updown2
  import score_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output bcd_digit_t tens,
  output bcd_digit_t ones,
  output bcd_digit_t nxt_tens,
  output bcd_digit_t nxt_ones
);

  bcd_digit_t tens_q, tens_d;
  bcd_digit_t ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc && !dec) begin
      if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end else if (dec && !inc) begin
      if (!(tens_q == 4'd0 && ones_q == 4'd0)) begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign nxt_tens = tens_d;
  assign nxt_ones = ones_d;

endmodule

// File: rtl/score_keeper.sv
// Game score and session high score, presented as ASCII digits that only
// change on the leading edge of vsync so the text renderer never tears.
module score_keeper
  import score_pkg::*;
#(
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       game_over,
  input  logic       hit,
  input  logic       miss,
  input  logic       vsync,
  output logic [6:0] score_MSB,
  output logic [6:0] score_LSB,
  output logic [6:0] hi_MSB,
  output logic [6:0] hi_LSB,
  output logic       playing
);

  localparam logic VSYNC_IDLE = VSYNC_ACTIVE_LOW;

  state_t     state_q, state_d;
  logic       hit_q, miss_q, vsync_q;
  logic       hit_ev, miss_ev, frame_ev;
  logic       cnt_clr, cnt_inc, cnt_dec, commit;
  bcd_digit_t tens, ones, nxt_tens, nxt_ones;
  bcd_digit_t hi_tens_q, hi_tens_d, hi_ones_q, hi_ones_d;
  logic [6:0] score_msb_q, score_msb_d, score_lsb_q, score_lsb_d;
  logic [6:0] hi_msb_q, hi_msb_d, hi_lsb_q, hi_lsb_d;

  assign hit_ev   = hit & ~hit_q;
  assign miss_ev  = miss & ~miss_q;
  assign frame_ev = VSYNC_ACTIVE_LOW ? (vsync_q & ~vsync) : (~vsync_q & vsync);

  bcd_updown2 u_score (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .tens     (tens),
    .ones     (ones),
    .nxt_tens (nxt_tens),
    .nxt_ones (nxt_ones)
  );

  // start outranks both scoring events and game_over; the commit sees the
  // post-event score so a hit landing with game_over still counts.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PLAY;
          cnt_clr = 1'b1;
        end
      end
      PLAY: begin
        if (start) begin
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = hit_ev;
          cnt_dec = miss_ev;
          if (game_over) begin
            state_d = IDLE;
            commit  = {nxt_tens, nxt_ones} > {hi_tens_q, hi_ones_q};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hi_tens_d   = commit ? nxt_tens : hi_tens_q;
    hi_ones_d   = commit ? nxt_ones : hi_ones_q;
    score_msb_d = score_msb_q;
    score_lsb_d = score_lsb_q;
    hi_msb_d    = hi_msb_q;
    hi_lsb_d    = hi_lsb_q;
    if (frame_ev) begin
      score_msb_d = ASCII_ZERO + {3'b000, tens};
      score_lsb_d = ASCII_ZERO + {3'b000, ones};
      hi_msb_d    = ASCII_ZERO + {3'b000, hi_tens_q};
      hi_lsb_d    = ASCII_ZERO + {3'b000, hi_ones_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      vsync_q     <= VSYNC_IDLE;
      hi_tens_q   <= 4'd0;
      hi_ones_q   <= 4'd0;
      score_msb_q <= ASCII_ZERO;
      score_lsb_q <= ASCII_ZERO;
      hi_msb_q    <= ASCII_ZERO;
      hi_lsb_q    <= ASCII_ZERO;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit;
      miss_q      <= miss;
      vsync_q     <= vsync;
      hi_tens_q   <= hi_tens_d;
      hi_ones_q   <= hi_ones_d;
      score_msb_q <= score_msb_d;
      score_lsb_q <= score_lsb_d;
      hi_msb_q    <= hi_msb_d;
      hi_lsb_q    <= hi_lsb_d;
    end
  end

  assign score_MSB = score_msb_q;
  assign score_LSB = score_lsb_q;
  assign hi_MSB    = hi_msb_q;
  assign hi_LSB    = hi_lsb_q;
  assign playing   = (state_q == PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// Directed and randomized checks of score_keeper against an integer-score model.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       vsync = 1'b1;
  logic [6:0] score_MSB, score_LSB, hi_MSB, hi_LSB;
  logic       playing;

  int n_assert = 0;
  int n_fail = 0;

  // Model: plain integer scores, displayed copies taken at frame edges.
  int m_score = 0;
  int m_hi = 0;
  int d_score = 0;
  int d_hi = 0;
  bit m_play = 1'b0;
  bit p_hit = 1'b0;
  bit p_miss = 1'b0;
  bit p_vs = 1'b1;

  score_keeper #(.VSYNC_ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .game_over (game_over),
    .hit       (hit),
    .miss      (miss),
    .vsync     (vsync),
    .score_MSB (score_MSB),
    .score_LSB (score_LSB),
    .hi_MSB    (hi_MSB),
    .hi_LSB    (hi_LSB),
    .playing   (playing)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] asc(int v);
    logic [6:0] r;
    r = 7'h30 + 7'(v);
    return r;
  endfunction

  task automatic tick();
    bit he, me, fe;
    @(posedge clk);
    if (reset) begin
      m_score = 0; m_hi = 0; d_score = 0; d_hi = 0;
      m_play = 1'b0; p_hit = 1'b0; p_miss = 1'b0; p_vs = 1'b1;
    end else begin
      he = hit && !p_hit;
      me = miss && !p_miss;
      fe = p_vs && !vsync;
      if (fe) begin
        d_score = m_score;
        d_hi = m_hi;
      end
      if (start) begin
        m_score = 0;
        m_play = 1'b1;
      end else if (m_play) begin
        if (he && !me && m_score < 99) m_score = m_score + 1;
        else if (me && !he && m_score > 0) m_score = m_score - 1;
        if (game_over) begin
          m_play = 1'b0;
          if (m_score > m_hi) m_hi = m_score;
        end
      end
      p_hit = hit; p_miss = miss; p_vs = vsync;
    end
    #1;
  endtask

  task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_score_msb"}, score_MSB, asc(d_score / 10));
    chk({tag, "_score_lsb"}, score_LSB, asc(d_score % 10));
    chk({tag, "_hi_msb"}, hi_MSB, asc(d_hi / 10));
    chk({tag, "_hi_lsb"}, hi_LSB, asc(d_hi % 10));
    chk({tag, "_playing"}, {6'b0, playing}, {6'b0, m_play});
  endtask

  task automatic hits(int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; tick();
      hit = 1'b0; tick();
    end
  endtask

  task automatic misses(int n);
    for (int i = 0; i < n; i++) begin
      miss = 1'b1; tick();
      miss = 1'b0; tick();
    end
  endtask

  task automatic frame();
    vsync = 1'b0; tick();
    vsync = 1'b1; tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic pulse_over();
    game_over = 1'b1; tick();
    game_over = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
  endtask

  initial begin
    do_reset();
    check_all("reset");
    chk("reset_lit_lsb", score_LSB, 7'h30);

    pulse_start();
    chk("start_playing", {6'b0, playing}, 7'd1);
    hits(3);
    check_all("pre_frame");
    chk("pre_frame_lsb", score_LSB, 7'h30);
    frame();
    check_all("three_hits");
    chk("three_hits_msb", score_MSB, 7'h30);
    chk("three_hits_lsb", score_LSB, 7'h33);

    hits(6);
    frame();
    chk("nine_lsb", score_LSB, 7'h39);
    hits(1);
    frame();
    check_all("carry");
    chk("carry_msb", score_MSB, 7'h31);
    chk("carry_lsb", score_LSB, 7'h30);
    misses(1);
    frame();
    check_all("borrow");
    chk("borrow_lsb", score_LSB, 7'h39);

    hits(105);
    frame();
    check_all("saturate");
    chk("sat_msb", score_MSB, 7'h39);
    chk("sat_lsb", score_LSB, 7'h39);

    pulse_start();
    misses(2);
    frame();
    check_all("floor");
    chk("floor_lsb", score_LSB, 7'h30);
    hits(5);
    hit = 1'b1; miss = 1'b1; tick();
    hit = 1'b0; miss = 1'b0; tick();
    frame();
    check_all("hit_and_miss");
    chk("hit_and_miss_lsb", score_LSB, 7'h35);

    // Game 1 ends on a hit coinciding with game_over: 41 + 1 = 42.
    pulse_start();
    hits(41);
    hit = 1'b1; game_over = 1'b1; tick();
    hit = 1'b0; game_over = 1'b0; tick();
    frame();
    check_all("game1");
    chk("game1_hi_lsb", hi_LSB, 7'h32);
    pulse_start();
    hits(17);
    pulse_over();
    frame();
    check_all("game2");
    chk("game2_hi_msb", hi_MSB, 7'h34);
    pulse_start();
    hits(57);
    pulse_over();
    frame();
    check_all("game3");
    chk("game3_hi_msb", hi_MSB, 7'h35);
    chk("game3_hi_lsb", hi_LSB, 7'h37);

    pulse_start();
    hit = 1'b1;
    repeat (1000) tick();
    hit = 1'b0; tick();
    frame();
    check_all("held");
    chk("held_lsb", score_LSB, 7'h31);

    pulse_over();
    hits(3);
    frame();
    check_all("idle_hits");
    chk("idle_hits_lsb", score_LSB, 7'h31);

    pulse_start();
    hits(4);
    hit = 1'b1; start = 1'b1; tick();
    hit = 1'b0; start = 1'b0; tick();
    frame();
    check_all("start_hit");
    chk("start_hit_lsb", score_LSB, 7'h30);

    do_reset();
    pulse_start();
    hits(50);
    pulse_over();
    pulse_start();
    hits(33);
    frame();
    chk("pre_reset_lsb", score_LSB, 7'h33);
    chk("pre_reset_hi_msb", hi_MSB, 7'h35);
    reset = 1'b1; tick();
    check_all("mid_reset");
    chk("mid_reset_hi_msb", hi_MSB, 7'h30);
    reset = 1'b0; tick();

    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 499) == 0);
      start     = ($urandom_range(0, 79) == 0);
      game_over = ($urandom_range(0, 59) == 0);
      hit       = ($urandom_range(0, 2) == 0);
      miss      = ($urandom_range(0, 4) == 0);
      vsync     = ((c % 50) >= 2);
      tick();
      check_all("rand");
    end
    reset = 1'b0; start = 1'b0; game_over = 1'b0; hit = 1'b0; miss = 1'b0; vsync = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
